// File: rtl/ram_arbiter.sv
// Shares the 2 KiB system RAM between the 65C02 and a DMA/loader port.
// The CPU has priority; a starved DMA request forces a one-cycle steal through cpu_rdy.
module ram_arbiter #(
  parameter int                 ADDR_W   = 11,
  parameter logic [15-ADDR_W:0] RAM_TAG  = '0,
  parameter int                 MAX_WAIT = 8,
  parameter int                 WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       cpu_ab,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_do,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [7:0]        dma_rdata,
  output logic [ADDR_W-1:0] ram_ad,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_STEAL = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              rd_dma_q;
  logic              rvalid_q;
  logic [7:0]        rdata_q;
  logic              cpu_ram;

  assign cpu_ram = (cpu_ab[15:ADDR_W] == RAM_TAG);

  // A CPU write is never blocked: the 65C02 cannot hold a write cycle.
  assign dma_gnt = dma_req & (~cpu_ram | ((state_q == S_STEAL) & ~cpu_we));
  assign cpu_rdy = (state_q != S_STEAL);

  always_comb begin
    if (dma_gnt) begin
      ram_ad  = dma_addr;
      ram_we  = dma_we;
      ram_din = dma_wdata;
      ram_ce  = 1'b1;
    end else begin
      ram_ad  = cpu_ab[ADDR_W-1:0];
      ram_we  = cpu_we;
      ram_din = cpu_do;
      ram_ce  = cpu_ram;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dma_req && !dma_gnt) begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      S_WAIT: begin
        if (dma_gnt || !dma_req) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          state_d = S_STEAL;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_STEAL: begin
        // Stays here only while the CPU keeps writing RAM (at most 3 pushes).
        if (dma_gnt || !dma_req) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      rd_dma_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_dma_q   <= dma_gnt & ~dma_we;
      rvalid_q   <= rd_dma_q;
      if (rd_dma_q) rdata_q <= ram_dout;
    end
  end

  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 2 KiB synchronous RAM.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_ab = 16'hF800;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_do = 8'h00;
  logic        cpu_rdy;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [10:0] dma_addr = 11'h000;
  logic [7:0]  dma_wdata = 8'h00;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;
  logic [10:0] ram_ad;
  logic        ram_ce;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = 8'h00;

  logic [7:0]  mem [0:2047];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_ad] <= ram_din;
      else        ram_dout    <= mem[ram_ad];
    end
  end

  ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_ad(ram_ad), .ram_ce(ram_ce), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (cpu_rdy !== 1'b1) begin $display("FAIL reset_rdy got %b want 1", cpu_rdy); n_err++; end
    n_vec++; if (dma_gnt !== 1'b0) begin $display("FAIL reset_gnt got %b want 0", dma_gnt); n_err++; end
    n_vec++; if (dma_rvalid !== 1'b0) begin $display("FAIL reset_rvalid got %b want 0", dma_rvalid); n_err++; end
    n_vec++; if (dma_rdata !== 8'h00) begin $display("FAIL reset_rdata got %h want 00", dma_rdata); n_err++; end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // CPU parked in ROM; DMA writes seed RAM locations used later.
  task automatic test_preload();
    logic [10:0] a [0:1];
    logic [7:0]  d [0:1];
    a[0] = 11'h123; d[0] = 8'h3C;
    a[1] = 11'h040; d[1] = 8'h77;
    cpu_ab = 16'hF800; cpu_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = a[k]; dma_wdata = d[k];
      #1;
      n_vec++; if (dma_gnt !== 1'b1 || ram_we !== 1'b1 || ram_ad !== a[k] || ram_din !== d[k])
        begin $display("FAIL preload_%0d gnt=%b we=%b ad=%h din=%h want 1 1 %h %h",
                       k, dma_gnt, ram_we, ram_ad, ram_din, a[k], d[k]); n_err++; end
    end
    @(negedge clk);
    dma_req = 1'b0; dma_we = 1'b0;
  endtask

  task automatic test_dma_read_idle();
    @(negedge clk);
    cpu_ab = 16'hF800; cpu_we = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 11'h123;
    #1;
    n_vec++; if (dma_gnt !== 1'b1 || ram_ce !== 1'b1 || ram_ad !== 11'h123)
      begin $display("FAIL idle_read_gnt gnt=%b ce=%b ad=%h want 1 1 123", dma_gnt, ram_ce, ram_ad); n_err++; end
    @(negedge clk);
    dma_req = 1'b0;
    #1;
    n_vec++; if (dma_rvalid !== 1'b0) begin $display("FAIL idle_read_early got %b want 0", dma_rvalid); n_err++; end
    @(negedge clk);
    #1;
    n_vec++; if (dma_rvalid !== 1'b1 || dma_rdata !== 8'h3C)
      begin $display("FAIL idle_read_data rvalid=%b rdata=%h want 1 3c", dma_rvalid, dma_rdata); n_err++; end
    @(negedge clk);
    #1;
    n_vec++; if (dma_rvalid !== 1'b0) begin $display("FAIL idle_read_pulse got %b want 0", dma_rvalid); n_err++; end
  endtask

  // CPU reads RAM every cycle; the steal must land on cycle 9.
  task automatic test_starvation_steal();
    logic exp_gnt, exp_rdy;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cpu_ab = 16'h0040; cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 11'h123;
      end
      if (c == 10) dma_req = 1'b0;
      #1;
      exp_gnt = (c == 9);
      exp_rdy = (c != 9);
      n_vec++; if (dma_gnt !== exp_gnt || cpu_rdy !== exp_rdy)
        begin $display("FAIL starve_c%0d gnt=%b rdy=%b want %b %b", c, dma_gnt, cpu_rdy, exp_gnt, exp_rdy); n_err++; end
      if (c == 11) begin
        n_vec++; if (dma_rvalid !== 1'b1 || dma_rdata !== 8'h3C)
          begin $display("FAIL starve_rdata rvalid=%b rdata=%h want 1 3c", dma_rvalid, dma_rdata); n_err++; end
      end
      if (c == 12) begin
        n_vec++; if (ram_dout !== 8'h77)
          begin $display("FAIL starve_cpu_read got %h want 77", ram_dout); n_err++; end
      end
    end
  endtask

  // Steal arrives while the CPU pushes three bytes; writes go through first.
  task automatic test_steal_cpu_pushes();
    logic exp_gnt, exp_rdy;
    logic [7:0] push [0:2];
    push[0] = 8'h11; push[1] = 8'h22; push[2] = 8'h33;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cpu_ab = 16'h0040; cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 11'h040;
      end
      if (c >= 9 && c <= 11) begin
        cpu_we = 1'b1; cpu_ab = 16'h01FD - 16'(c - 9); cpu_do = push[c-9];
      end
      if (c == 12) begin cpu_we = 1'b0; cpu_ab = 16'h0040; end
      if (c == 13) dma_req = 1'b0;
      #1;
      if (c <= 13) begin
        exp_gnt = (c == 12);
        exp_rdy = !(c >= 9 && c <= 12);
        n_vec++; if (dma_gnt !== exp_gnt || cpu_rdy !== exp_rdy)
          begin $display("FAIL push_c%0d gnt=%b rdy=%b want %b %b", c, dma_gnt, cpu_rdy, exp_gnt, exp_rdy); n_err++; end
      end
      if (c >= 9 && c <= 11) begin
        n_vec++; if (ram_we !== 1'b1 || ram_ad !== 11'(16'h01FD - 16'(c - 9)) || ram_din !== push[c-9])
          begin $display("FAIL push_wr_c%0d we=%b ad=%h din=%h", c, ram_we, ram_ad, ram_din); n_err++; end
      end
      if (c == 14) begin
        n_vec++; if (dma_rvalid !== 1'b1 || dma_rdata !== 8'h77)
          begin $display("FAIL push_rdata rvalid=%b rdata=%h want 1 77", dma_rvalid, dma_rdata); n_err++; end
      end
    end
  endtask

  task automatic test_dma_write_cpu_read();
    @(negedge clk);
    cpu_ab = 16'hF800; cpu_we = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 11'h010; dma_wdata = 8'hA5;
    #1;
    n_vec++; if (dma_gnt !== 1'b1) begin $display("FAIL dmawr_gnt got %b want 1", dma_gnt); n_err++; end
    @(negedge clk);
    dma_req = 1'b0; dma_we = 1'b0; cpu_ab = 16'h0010;
    @(negedge clk);
    #1;
    n_vec++; if (ram_dout !== 8'hA5) begin $display("FAIL dmawr_cpu_sees got %h want a5", ram_dout); n_err++; end
    cpu_we = 1'b1; cpu_do = 8'h5A;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 11'h010; dma_wdata = 8'h99;
    #1;
    n_vec++; if (dma_gnt !== 1'b0 || ram_we !== 1'b1 || ram_din !== 8'h5A || cpu_rdy !== 1'b1)
      begin $display("FAIL contest_cpu_wins gnt=%b we=%b din=%h rdy=%b want 0 1 5a 1", dma_gnt, ram_we, ram_din, cpu_rdy); n_err++; end
    @(negedge clk);
    dma_req = 1'b0; dma_we = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    #1;
    n_vec++; if (ram_dout !== 8'h5A || cpu_rdy !== 1'b1)
      begin $display("FAIL contest_readback dout=%h rdy=%b want 5a 1", ram_dout, cpu_rdy); n_err++; end
    cpu_ab = 16'hF800;
  endtask

  task automatic test_back_to_back();
    logic [10:0] a [0:3];
    logic [7:0]  d [0:3];
    a[0] = 11'h1FD; d[0] = 8'h11;
    a[1] = 11'h1FC; d[1] = 8'h22;
    a[2] = 11'h1FB; d[2] = 8'h33;
    a[3] = 11'h010; d[3] = 8'h5A;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k < 4) begin dma_req = 1'b1; dma_we = 1'b0; dma_addr = a[k]; end
      else dma_req = 1'b0;
      #1;
      if (k < 4) begin
        n_vec++; if (dma_gnt !== 1'b1) begin $display("FAIL b2b_gnt_%0d got %b want 1", k, dma_gnt); n_err++; end
      end
      if (k >= 2 && k <= 5) begin
        n_vec++; if (dma_rvalid !== 1'b1 || dma_rdata !== d[k-2])
          begin $display("FAIL b2b_data_%0d rvalid=%b rdata=%h want 1 %h", k-2, dma_rvalid, dma_rdata, d[k-2]); n_err++; end
      end
      if (k == 6) begin
        n_vec++; if (dma_rvalid !== 1'b0) begin $display("FAIL b2b_end got %b want 0", dma_rvalid); n_err++; end
      end
    end
  endtask

  task automatic test_reset_in_steal();
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cpu_ab = 16'h0040; cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 11'h123;
      end
    end
    #1;
    n_vec++; if (cpu_rdy !== 1'b0 || dma_gnt !== 1'b1)
      begin $display("FAIL rst_steal_pre rdy=%b gnt=%b want 0 1", cpu_rdy, dma_gnt); n_err++; end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (cpu_rdy !== 1'b1) begin $display("FAIL rst_steal_rdy got %b want 1", cpu_rdy); n_err++; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    dma_req = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      n_vec++; if (dma_rvalid !== 1'b0 || cpu_rdy !== 1'b1)
        begin $display("FAIL rst_after_%0d rvalid=%b rdy=%b want 0 1", c, dma_rvalid, cpu_rdy); n_err++; end
    end
    @(negedge clk);
    dma_req = 1'b1;
    #1;
    n_vec++; if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b1)
      begin $display("FAIL rst_idle_state gnt=%b rdy=%b want 0 1", dma_gnt, cpu_rdy); n_err++; end
    @(negedge clk);
    dma_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_preload();
    test_dma_read_idle();
    test_starvation_steal();
    test_steal_cpu_pushes();
    test_dma_write_cpu_read();
    test_back_to_back();
    test_reset_in_steal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
